// File: rtl/io_hub_if.sv
// Board-I/O bundle between the pins/core and io_hub.
// Carries raw buttons, the IMU data word and LED mode in; debounced buttons, tick and LEDs out.
// master drives the pin/core side; slave is the io_hub side.
interface io_hub_if #(
    parameter int NUM_BTN = 4,
    parameter int DATA_W  = 96
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [DATA_W-1:0]  data_in;
    logic               data_valid;
    logic [1:0]         dbg_mode;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic               tick;
    logic [7:0]         led;

    modport master (
        output btn_raw, data_in, data_valid, dbg_mode,
        input  btn_level, btn_press, btn_release, tick, led
    );

    modport slave (
        input  btn_raw, data_in, data_valid, dbg_mode,
        output btn_level, btn_press, btn_release, tick, led
    );
endinterface

// File: rtl/io_hub.sv
// Board-I/O front end: button sync/debounce with edge pulses, physics tick enable, debug LED bank.
// Latency: button 2+DEBOUNCE_CYCLES edges; tick one cycle after counter wrap; led one cycle behind mode/snapshot.
// No backpressure: every input is sampled each cycle, every output is registered.
// Ports: clk, reset (async active-high), bus (io_hub_if.slave: btn_raw, data_in, data_valid, dbg_mode in;
//        btn_level, btn_press, btn_release, tick, led out).
module io_hub #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TICK_DIV        = 4,
    parameter int DATA_W          = 96,
    parameter int HI_NIB          = 11,
    parameter int LO_NIB          = 7,
    parameter int SCAN_TICKS      = 64
) (
    input  logic clk,
    input  logic reset,
    io_hub_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int NP = DATA_W / 8;
    localparam int PW = (NP > 1) ? $clog2(NP) : 1;

    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SCAN_TICKS - 1);
    localparam logic [PW-1:0] P_LAST = PW'(NP - 1);

    // ---------------- buttons ----------------
    logic [NUM_BTN-1:0] sync1, sync2;
    logic [NUM_BTN-1:0] level_q, press_q, rel_q;
    logic [CW-1:0]      cnt [NUM_BTN];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            level_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
            for (int i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
        end else begin
            sync1 <= bus.btn_raw;
            sync2 <= sync1;
            for (int i = 0; i < NUM_BTN; i++) begin
                press_q[i] <= 1'b0;
                rel_q[i]   <= 1'b0;
                if (sync2[i] == level_q[i]) begin
                    // any return to the accepted level restarts the stability count
                    cnt[i] <= '0;
                end else if (cnt[i] == C_LAST) begin
                    level_q[i] <= sync2[i];
                    cnt[i]     <= '0;
                    press_q[i] <= sync2[i];
                    rel_q[i]   <= ~sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // ---------------- tick + heartbeat ----------------
    logic [TW-1:0] t;
    logic          tick_q;
    logic          hb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t      <= '0;
            tick_q <= 1'b0;
            hb     <= 1'b0;
        end else begin
            tick_q <= (t == T_LAST);
            if (t == T_LAST) begin
                t  <= '0;
                hb <= ~hb;
            end else begin
                t <= t + TW'(1);
            end
        end
    end

    // ---------------- snapshot + LEDs ----------------
    logic [DATA_W-1:0] snap;
    logic [7:0]        led_q;
    logic [7:0]        scan_byte;
    logic [PW-1:0]     p;
    logic [SW-1:0]     sc;

    // pair p is nibbles {2p+1, 2p}, i.e. byte p of the snapshot
    always_comb begin
        scan_byte = '0;
        for (int i = 0; i < NP; i++) begin
            if (p == PW'(i)) scan_byte = snap[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap  <= '0;
            led_q <= '0;
            p     <= '0;
            sc    <= '0;
        end else begin
            if (bus.data_valid) snap <= bus.data_in;

            // scan position only advances while scanning; leaving scan rewinds to pair 0
            if (bus.dbg_mode == 2'd2) begin
                if (tick_q) begin
                    if (sc == S_LAST) begin
                        sc <= '0;
                        p  <= (p == P_LAST) ? '0 : p + PW'(1);
                    end else begin
                        sc <= sc + SW'(1);
                    end
                end
            end else begin
                p  <= '0;
                sc <= '0;
            end

            case (bus.dbg_mode)
                2'd0:    led_q <= {snap[4*HI_NIB +: 4], snap[4*LO_NIB +: 4]};
                2'd1:    led_q <= {hb, 7'(level_q)};
                2'd2:    led_q <= scan_byte;
                default: led_q <= led_q;
            endcase
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = rel_q;
    assign bus.tick        = tick_q;
    assign bus.led         = led_q;
endmodule

// File: tb/tb_io_hub.sv
// Self-checking bench for io_hub: dut_a uses default parameters, dut_b uses TICK_DIV=2, SCAN_TICKS=2.
// Inputs are driven on the falling edge, outputs sampled 1 time unit after the rising edge.
// Expected values come from directed tables and an edge counter kept by the bench.
module tb_io_hub;
    localparam int NB = 4;
    localparam int DW = 96;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    io_hub_if #(.NUM_BTN(NB), .DATA_W(DW)) bus_a ();
    io_hub_if #(.NUM_BTN(NB), .DATA_W(DW)) bus_b ();

    io_hub #(.NUM_BTN(NB), .DATA_W(DW)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    io_hub #(.NUM_BTN(NB), .DATA_W(DW), .TICK_DIV(2), .SCAN_TICKS(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    int checks = 0;
    int errors = 0;

    // rising edges since the last reset release
    int edge_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] ramp_data();
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < DW/4; k++) d[4*k +: 4] = 4'(k % 16);
        return d;
    endfunction

    function automatic logic [7:0] pair_val(input int j);
        return {4'((2*j + 1) % 16), 4'((2*j) % 16)};
    endfunction

    // button observation results, indexed by bit; 0 means "never seen"
    int lvl_e [NB];
    int pr_e  [NB];
    int rl_e  [NB];
    int pr_n, rl_n;

    task automatic watch_btn(input int ncyc);
        logic [NB-1:0] start;
        start = bus_a.btn_level;
        pr_n = 0;
        rl_n = 0;
        for (int b = 0; b < NB; b++) begin
            lvl_e[b] = 0; pr_e[b] = 0; rl_e[b] = 0;
        end
        for (int n = 1; n <= ncyc; n++) begin
            step();
            for (int b = 0; b < NB; b++) begin
                if (lvl_e[b] == 0 && bus_a.btn_level[b] != start[b]) lvl_e[b] = n;
                if (bus_a.btn_press[b]) begin
                    pr_n++;
                    if (pr_e[b] == 0) pr_e[b] = n;
                end
                if (bus_a.btn_release[b]) begin
                    rl_n++;
                    if (rl_e[b] == 0) rl_e[b] = n;
                end
            end
        end
    endtask

    typedef struct {
        logic [1:0]    mode;
        logic          valid;
        logic [DW-1:0] data;
        logic [7:0]    exp_led;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [DW-1:0] d_ramp, d_inv;
        logic [7:0]    prev;
        int            idx, last_chg;
        logic          hb_e;

        d_ramp = ramp_data();
        d_inv  = ~d_ramp;
        // led after each edge reflects the snapshot taken on the previous edge
        vecs[0] = '{2'd0, 1'b1, d_ramp, 8'h00};
        vecs[1] = '{2'd0, 1'b0, d_inv,  8'hB7};
        vecs[2] = '{2'd0, 1'b0, d_inv,  8'hB7};
        vecs[3] = '{2'd3, 1'b1, d_inv,  8'hB7};
        vecs[4] = '{2'd3, 1'b0, d_ramp, 8'hB7};
        vecs[5] = '{2'd0, 1'b0, d_ramp, 8'h48};
        vecs[6] = '{2'd0, 1'b0, d_ramp, 8'h48};

        reset = 1'b1;
        bus_a.btn_raw = '0; bus_a.data_in = '0; bus_a.data_valid = 1'b0; bus_a.dbg_mode = 2'd0;
        bus_b.btn_raw = '0; bus_b.data_in = '0; bus_b.data_valid = 1'b0; bus_b.dbg_mode = 2'd0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_outs", 32'({bus_a.btn_level, bus_a.btn_press, bus_a.btn_release, bus_a.tick, bus_a.led}), 32'd0);
        check("rst_b_outs", 32'({bus_b.tick, bus_b.led}), 32'd0);

        // ---- idle after release: tick on every 4th edge ----
        @(negedge clk);
        reset = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            step();
            check("idle_tick", 32'(bus_a.tick), 32'((edge_cnt % 4 == 0) && (edge_cnt != 0)));
            check("idle_outs", 32'({bus_a.btn_level, bus_a.btn_press, bus_a.btn_release, bus_a.led}), 32'd0);
        end

        // ---- asynchronous reset while tick is high, then restart ----
        reset = 1'b1;
        #1;
        check("rst_mid_tick", 32'(bus_a.tick), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            step();
            check("restart_tick", 32'(bus_a.tick), 32'((edge_cnt % 4 == 0) && (edge_cnt != 0)));
        end

        // ---- snapshot / mode 0 / mode 3 table ----
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus_a.dbg_mode   = vecs[i].mode;
            bus_a.data_valid = vecs[i].valid;
            bus_a.data_in    = vecs[i].data;
            step();
            check("mode_led", 32'(bus_a.led), 32'(vecs[i].exp_led));
        end
        @(negedge clk);
        bus_a.data_valid = 1'b0;

        // ---- press and release of bit 2 ----
        bus_a.btn_raw[2] = 1'b1;
        watch_btn(30);
        check("press2_level_edge", 32'(lvl_e[2]), 32'd18);
        check("press2_pulse_edge", 32'(pr_e[2]), 32'd18);
        check("press2_pulse_cnt", 32'(pr_n), 32'd1);
        check("press2_no_release", 32'(rl_n), 32'd0);

        @(negedge clk);
        bus_a.btn_raw[2] = 1'b0;
        watch_btn(30);
        check("rel2_level_edge", 32'(lvl_e[2]), 32'd18);
        check("rel2_pulse_edge", 32'(rl_e[2]), 32'd18);
        check("rel2_pulse_cnt", 32'(rl_n), 32'd1);
        check("rel2_no_press", 32'(pr_n), 32'd0);

        // ---- 10-cycle glitch on bit 0 ----
        @(negedge clk);
        bus_a.btn_raw[0] = 1'b1;
        repeat (10) @(negedge clk);
        bus_a.btn_raw[0] = 1'b0;
        watch_btn(30);
        check("glitch_level", 32'(bus_a.btn_level), 32'd0);
        check("glitch_pulses", 32'(pr_n + rl_n), 32'd0);

        // ---- simultaneous press on bits 0 and 3 ----
        @(negedge clk);
        bus_a.btn_raw = 4'b1001;
        watch_btn(30);
        check("sim_level0_edge", 32'(lvl_e[0]), 32'd18);
        check("sim_level3_edge", 32'(lvl_e[3]), 32'd18);
        check("sim_press0_edge", 32'(pr_e[0]), 32'd18);
        check("sim_press3_edge", 32'(pr_e[3]), 32'd18);
        check("sim_level", 32'(bus_a.btn_level), 32'h9);

        // ---- mode 1: heartbeat + buttons ----
        @(negedge clk);
        bus_a.btn_raw = 4'b0101;
        repeat (25) step();
        check("m1_level", 32'(bus_a.btn_level), 32'h5);
        @(negedge clk);
        bus_a.dbg_mode = 2'd1;
        for (int n = 0; n < 12; n++) begin
            step();
            hb_e = (((edge_cnt - 1) / 4) % 2) != 0;
            check("m1_led", 32'(bus_a.led), 32'({hb_e, 7'b0000101}));
        end
        @(negedge clk);
        bus_a.dbg_mode = 2'd0;

        // ---- scan mode on dut_b ----
        bus_b.data_in    = d_ramp;
        bus_b.data_valid = 1'b1;
        @(negedge clk);
        bus_b.data_valid = 1'b0;
        @(negedge clk);
        bus_b.dbg_mode = 2'd2;
        step();
        check("scan_start", 32'(bus_b.led), 32'h10);
        prev     = bus_b.led;
        idx      = 0;
        last_chg = 0;
        for (int cyc = 1; cyc <= 80 && idx < 12; cyc++) begin
            step();
            if (bus_b.led != prev) begin
                idx++;
                check("scan_val", 32'(bus_b.led), 32'(pair_val(idx % 12)));
                if (idx >= 2) check("scan_gap", 32'(cyc - last_chg), 32'd4);
                last_chg = cyc;
                prev     = bus_b.led;
            end
        end
        check("scan_steps", 32'(idx), 32'd12);
        repeat (5) step();
        check("scan_pre_hold", 32'(bus_b.led), 32'h32);

        @(negedge clk);
        bus_b.dbg_mode = 2'd3;
        for (int n = 0; n < 12; n++) begin
            step();
            check("hold_led", 32'(bus_b.led), 32'h32);
        end
        @(negedge clk);
        bus_b.dbg_mode = 2'd2;
        step();
        check("scan_restart", 32'(bus_b.led), 32'h10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
